// File: rtl/dmem_access_unit.sv
// Data-memory access unit for the M stage; optional store trace under DMEM_TRACE_EN.
// Latency: LATENCY cycles from accept to rsp_valid; misaligned requests respond after 1 cycle.
// Backpressure: busy is high while an access waits; req_valid is ignored then and must be held.
module dmem_access_unit #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        busy,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        misalign_err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] mem [2**ADDR_W];

    logic        r_we;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_pc;

    logic              accept;
    logic              op_we;
    logic [1:0]        op_size;
    logic              op_signed;
    logic [31:0]       op_addr;
    logic [31:0]       op_wdata;
    logic              misaligned;
    logic              do_access;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       old_word;
    logic [31:0]       merged;
    logic [31:0]       load_data;
    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;
    logic              unused_bits;

    assign accept = req_valid && (state == IDLE || state == RESP);

    // The access uses live inputs on an accept edge, otherwise the captured request.
    always_comb begin
        op_we     = accept ? req_we     : r_we;
        op_size   = accept ? req_size   : r_size;
        op_signed = accept ? req_signed : r_signed;
        op_addr   = accept ? req_addr   : r_addr;
        op_wdata  = accept ? req_wdata  : r_wdata;
    end

    assign misaligned = (op_size == 2'd1 && op_addr[0]) || (op_size[1] && op_addr[1:0] != 2'b00);
    assign do_access  = (accept && !misaligned && LATENCY == 1) || (state == WAIT && cnt == 4'd1);
    assign idx        = op_addr[ADDR_W+1:2];
    assign old_word   = mem[idx];
    assign sel_byte   = old_word[{op_addr[1:0], 3'b000} +: 8];
    assign sel_half   = old_word[{op_addr[1], 4'b0000} +: 16];
    assign unused_bits = ^{req_pc, r_pc, op_addr[31:ADDR_W+2]};

    always_comb begin
        merged    = old_word;
        load_data = old_word;
        case (op_size)
            2'd0: begin
                merged[{op_addr[1:0], 3'b000} +: 8] = op_wdata[7:0];
                load_data = op_signed ? {{24{sel_byte[7]}}, sel_byte} : {24'b0, sel_byte};
            end
            2'd1: begin
                merged[{op_addr[1], 4'b0000} +: 16] = op_wdata[15:0];
                load_data = op_signed ? {{16{sel_half[15]}}, sel_half} : {16'b0, sel_half};
            end
            default: merged = op_wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 32'b0;
            misalign_err <= 1'b0;
            cnt          <= 4'd0;
            r_we         <= 1'b0;
            r_size       <= 2'd0;
            r_signed     <= 1'b0;
            r_addr       <= 32'b0;
            r_wdata      <= 32'b0;
            r_pc         <= 32'b0;
            for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= 32'b0;
        end else begin
            if (do_access && op_we) begin
                mem[idx] <= merged;
`ifdef DMEM_TRACE_EN
                $display("@%h: *%h <= %h", accept ? req_pc : r_pc, {op_addr[31:2], 2'b00}, merged);
`endif
            end
            if (accept) begin
                r_we     <= req_we;
                r_size   <= req_size;
                r_signed <= req_signed;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_pc     <= req_pc;
                if (misaligned) begin
                    state        <= RESP;
                    busy         <= 1'b0;
                    rsp_valid    <= 1'b1;
                    rsp_rdata    <= 32'b0;
                    misalign_err <= 1'b1;
                    cnt          <= 4'd0;
                end else if (LATENCY == 1) begin
                    state        <= RESP;
                    busy         <= 1'b0;
                    rsp_valid    <= 1'b1;
                    rsp_rdata    <= req_we ? 32'b0 : load_data;
                    misalign_err <= 1'b0;
                    cnt          <= 4'd0;
                end else begin
                    state        <= WAIT;
                    busy         <= 1'b1;
                    rsp_valid    <= 1'b0;
                    misalign_err <= 1'b0;
                    cnt          <= 4'(LATENCY - 1);
                end
            end else begin
                case (state)
                    WAIT: begin
                        if (cnt == 4'd1) begin
                            state        <= RESP;
                            busy         <= 1'b0;
                            rsp_valid    <= 1'b1;
                            rsp_rdata    <= r_we ? 32'b0 : load_data;
                            misalign_err <= 1'b0;
                            cnt          <= 4'd0;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    RESP: begin
                        state        <= IDLE;
                        rsp_valid    <= 1'b0;
                        misalign_err <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: a default-size and a 16-word instance share stimulus,
// responses are checked against a scoreboard of expected load results.
module tb_dmem_access_unit;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        busy, rsp_valid, misalign_err;
    logic [31:0] rsp_rdata;
    logic        s_busy, s_rsp_valid, s_misalign_err;
    logic [31:0] s_rsp_rdata;

    typedef struct {
        string       tag;
        logic [31:0] rd;
        logic        err;
        logic [31:0] srd;
    } exp_t;

    exp_t sb[$];
    int   n_asrt = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    dmem_access_unit #(.ADDR_W(10), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_pc(req_pc), .busy(busy), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .misalign_err(misalign_err)
    );

    dmem_access_unit #(.ADDR_W(4), .LATENCY(LAT)) u_dut_small (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_pc(req_pc), .busy(s_busy), .rsp_valid(s_rsp_valid),
        .rsp_rdata(s_rsp_rdata), .misalign_err(s_misalign_err)
    );

    task automatic chk(input string tag, input bit ok, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_asrt++;
        if (!ok) begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Response monitor: every rsp_valid pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1 || s_rsp_valid === 1'b1) begin
            chk("rsp_expected", sb.size() > 0, sb.size(), 32'd1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk({e.tag, "_valid_small"}, s_rsp_valid === 1'b1, s_rsp_valid, 1'b1);
                chk({e.tag, "_rdata"}, rsp_rdata === e.rd, rsp_rdata, e.rd);
                chk({e.tag, "_err"}, misalign_err === e.err, misalign_err, e.err);
                chk({e.tag, "_rdata_small"}, s_rsp_rdata === e.srd, s_rsp_rdata, e.srd);
                chk({e.tag, "_err_small"}, s_misalign_err === e.err, s_misalign_err, e.err);
            end
        end
    end

    task automatic access(input string tag, input logic we, input logic [1:0] sz,
                          input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input logic [31:0] exp_srd);
        int lat;
        int exp_lat;
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        req_pc     = 32'h0040_0000 + addr;
        sb.push_back('{tag, exp_rd, exp_err, exp_srd});
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_wdata = 32'hFFFF_FFFF;
        req_addr  = 32'hFFFF_FFFF;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            chk({tag, "_busy_wait"}, busy === 1'b1, busy, 1'b1);
            @(posedge clk); #1;
            lat++;
        end
        exp_lat = exp_err ? 1 : LAT;
        chk({tag, "_latency"}, lat == exp_lat, lat, exp_lat);
        chk({tag, "_busy_resp"}, busy === 1'b0, busy, 1'b0);
        @(posedge clk); #1;
        chk({tag, "_pulse_end"}, rsp_valid === 1'b0, rsp_valid, 1'b0);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 32'b0;
        req_wdata  = 32'b0;
        req_pc     = 32'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_busy", busy === 1'b0, busy, 1'b0);
        chk("reset_rsp_valid", rsp_valid === 1'b0, rsp_valid, 1'b0);
        chk("reset_rdata", rsp_rdata === 32'h0, rsp_rdata, 32'h0);
        chk("reset_err", misalign_err === 1'b0, misalign_err, 1'b0);

        // Word store / load
        access("sw_10", 1, 2'd2, 0, 32'h10, 32'h12345678, 32'h0, 0, 32'h0);
        access("lw_10", 0, 2'd2, 0, 32'h10, 32'h0, 32'h12345678, 0, 32'h12345678);
        // Byte store into the top lane, signed and unsigned byte loads
        access("sb_13", 1, 2'd0, 0, 32'h13, 32'hFFFF_FFAB, 32'h0, 0, 32'h0);
        access("lw_10b", 0, 2'd2, 0, 32'h10, 32'h0, 32'hAB345678, 0, 32'hAB345678);
        access("lb_13", 0, 2'd0, 1, 32'h13, 32'h0, 32'hFFFFFFAB, 0, 32'hFFFFFFAB);
        access("lbu_13", 0, 2'd0, 0, 32'h13, 32'h0, 32'h000000AB, 0, 32'h000000AB);
        access("lb_10", 0, 2'd0, 1, 32'h10, 32'h0, 32'h00000078, 0, 32'h00000078);
        access("lw_sz3", 0, 2'd3, 0, 32'h10, 32'h0, 32'hAB345678, 0, 32'hAB345678);
        // Half store into upper half; lower half must survive
        access("sw_20", 1, 2'd2, 0, 32'h20, 32'hCAFEF00D, 32'h0, 0, 32'h0);
        access("sh_22", 1, 2'd1, 0, 32'h22, 32'h1234_8001, 32'h0, 0, 32'h0);
        access("lh_22", 0, 2'd1, 1, 32'h22, 32'h0, 32'hFFFF8001, 0, 32'hFFFF8001);
        access("lhu_22", 0, 2'd1, 0, 32'h22, 32'h0, 32'h00008001, 0, 32'h00008001);
        access("lhu_20", 0, 2'd1, 0, 32'h20, 32'h0, 32'h0000F00D, 0, 32'h0000F00D);
        access("lh_20", 0, 2'd1, 1, 32'h20, 32'h0, 32'hFFFFF00D, 0, 32'hFFFFF00D);
        access("lw_20", 0, 2'd2, 0, 32'h20, 32'h0, 32'h8001F00D, 0, 32'h8001F00D);
        // Misaligned accesses respond next cycle with no side effects
        access("lw_06_mis", 0, 2'd2, 0, 32'h06, 32'h0, 32'h0, 1, 32'h0);
        access("sh_21_mis", 1, 2'd1, 0, 32'h21, 32'h0000_7777, 32'h0, 1, 32'h0);
        access("lh_23_mis", 0, 2'd1, 1, 32'h23, 32'h0, 32'h0, 1, 32'h0);
        access("lw_20_re", 0, 2'd2, 0, 32'h20, 32'h0, 32'h8001F00D, 0, 32'h8001F00D);
        access("lw_04", 0, 2'd2, 0, 32'h04, 32'h0, 32'h0, 0, 32'h0);

        // Reset during WAIT of a store aborts it
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_size   = 2'd2;
        req_signed = 1'b0;
        req_addr   = 32'h30;
        req_wdata  = 32'hDEADBEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("abort_busy_wait", busy === 1'b1, busy, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", busy === 1'b0, busy, 1'b0);
        chk("abort_rsp_valid", rsp_valid === 1'b0, rsp_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("abort_no_rsp", rsp_valid === 1'b0, rsp_valid, 1'b0);
        end
        access("lw_30_abort", 0, 2'd2, 0, 32'h30, 32'h0, 32'h0, 0, 32'h0);
        access("lw_20_clr", 0, 2'd2, 0, 32'h20, 32'h0, 32'h0, 0, 32'h0);

        // Address wrap: 0x40 is word 16 in the large memory, word 0 in the 16-word one
        access("sw_40", 1, 2'd2, 0, 32'h40, 32'h00000055, 32'h0, 0, 32'h0);
        access("lw_00_wrap", 0, 2'd2, 0, 32'h00, 32'h0, 32'h0, 0, 32'h00000055);
        access("lw_40", 0, 2'd2, 0, 32'h40, 32'h0, 32'h00000055, 0, 32'h00000055);

        // Back-to-back: new request accepted while in RESP
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_size   = 2'd2;
        req_addr   = 32'h40;
        sb.push_back('{"b2b_a", 32'h55, 1'b0, 32'h55});
        @(posedge clk); #1;
        chk("b2b_a_busy", busy === 1'b1, busy, 1'b1);
        @(posedge clk); #1;
        chk("b2b_a_valid", rsp_valid === 1'b1, rsp_valid, 1'b1);
        req_addr = 32'h00;
        sb.push_back('{"b2b_b", 32'h0, 1'b0, 32'h55});
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("b2b_b_busy", busy === 1'b1, busy, 1'b1);
        @(posedge clk); #1;
        chk("b2b_b_valid", rsp_valid === 1'b1, rsp_valid, 1'b1);
        @(posedge clk); #1;
        chk("b2b_idle", rsp_valid === 1'b0, rsp_valid, 1'b0);

        chk("scoreboard_empty", sb.size() == 0, sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Parametrised data-memory access unit for the M stage of the pipelined MIPS core.
- Generalises single-cycle word/byte access to byte, halfword and word loads and stores, signed or unsigned.
- Adds configurable memory depth, a configurable multi-cycle access latency with a stall handshake, and misalignment detection.
- Sits between the E/M pipeline register and the W stage; `busy` drives the hazard unit's stall.

Parameters:
- ADDR_W, 10, word-address bits; memory holds 2^ADDR_W 32-bit words.
- LATENCY, 2, cycles from request acceptance to response; legal range 1..15.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  access request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 halfword, 2 word; 3 reserved, treated as word.
- req_signed  in  1  load sign-extension select (lb/lh = 1, lbu/lhu = 0).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_pc  in  32  PC of the instruction, for trace only.
- busy  out  1  unit cannot accept a request this cycle; pipeline must hold.
- rsp_valid  out  1  one-cycle pulse; response fields are valid.
- rsp_rdata  out  32  load result, extended per size/sign; 0 for stores.
- misalign_err  out  1  qualified by rsp_valid; request was misaligned.

Behaviour:
- Reset: state IDLE; busy = 0, rsp_valid = 0, rsp_rdata = 0, misalign_err = 0, latency counter = 0.
- Reset also clears every memory word to 0, taking one cycle.
- A reset mid-operation aborts the access: no write occurs and no response is produced.
- States:
  - IDLE: no access in flight.
  - WAIT: counter running; busy = 1 only in this state.
  - RESP: rsp_valid = 1 for exactly one cycle.
- Acceptance: a request is accepted at an edge where req_valid = 1 and state is IDLE or RESP. Back-to-back issue is allowed, giving one access per LATENCY cycles.
- Request fields are registered at acceptance; inputs may change afterwards.
- Transitions after acceptance:
  - LATENCY = 1: go to RESP.
  - LATENCY > 1: go to WAIT with count = LATENCY-1. Decrement each cycle; when count = 1, go to RESP on the next edge.
  - In every case rsp_valid is high in the LATENCY-th cycle after the accept edge.
- RESP with no new request: go to IDLE.
- req_valid during WAIT is ignored; the requester must hold it.
- Alignment:
  - half requires addr[0] = 0.
  - word requires addr[1:0] = 0.
  - Misaligned requests skip the latency: go to RESP on the next edge with misalign_err = 1, rsp_rdata = 0, and no memory write.
- Word index is addr[ADDR_W+1:2]; upper address bits are ignored, so addresses wrap modulo memory size.
- Store lanes:
  - byte: write req_wdata[7:0] to lane addr[1:0]; other lanes unchanged.
  - half: write req_wdata[15:0] to lanes {1,0} or {3,2} per addr[1].
  - word: write all lanes.
- Store timing: the write commits on the edge entering RESP. A load issued later always sees the new data.
- Load extraction: the word is read on the edge entering RESP. Select the byte by addr[1:0] or the half by addr[1], then sign- or zero-extend per req_signed. A word load returns the word unchanged.

Optional Feature:
- Macro: DMEM_TRACE_EN.
- Defined: on every committed store, $display "@%h: *%h <= %h" using req_pc, the word-aligned byte address, and the full merged 32-bit word written.
- Not defined: no display statements are compiled; functional behaviour is identical.

Test Plan:
- Reset, then LATENCY = 2: word store 0x12345678 to 0x10, then word load 0x10 → busy high 1 cycle per access, rsp_valid 2 cycles after each accept, rsp_rdata = 0x12345678.
- Byte store 0xAB to 0x13 over word 0x12345678, then lb 0x13 and lbu 0x13 → word = 0xAB345678; lb = 0xFFFFFFAB; lbu = 0x000000AB.
- Half store 0x8001 to 0x22, then lh 0x22 and lhu 0x22 → lh = 0xFFFF8001, lhu = 0x00008001, lanes [15:0] unchanged.
- Misaligned word load at 0x06 and half store at 0x21 → rsp_valid next cycle with misalign_err = 1, rsp_rdata = 0; memory unchanged on reload.
- Reset asserted during WAIT of a store 0xDEADBEEF → no rsp_valid; a following load of that address returns 0.
- ADDR_W = 4: store 0x55 at byte 0x40 (wraps to word 0), then word load 0x00 → rsp_rdata = 0x00000055.
